calc_disp_seq: RTL and testbench

Display sequencer for the calculator datapath. It takes a binary result or operand from the calculator core on a start/busy/done handshake and converts it to BCD with a multi-cycle double-dabble. It then emits the decimal digits one per cycle as `data`/`pos` pairs for the display controller. It replaces the divide-by-10 loop in the core with a fixed-latency, divider-free schedule.

---
 rtl/calc_disp_seq.sv | 150 +++++++++++++++
 tb/tb_calc_disp_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/calc_disp_seq.sv
// rtl/calc_disp_seq.sv - binary to BCD display sequencer (double-dabble, one digit per cycle out)
module calc_disp_seq #(
    parameter int WIDTH  = 27,
    parameter int DIGITS = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             valid,
    output logic [3:0]       data,
    output logic [3:0]       pos,
    output logic             blank,
    output logic             overflow,
    output logic             done
);

    localparam int BW = DIGITS * 4;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_EMIT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    iter_q, iter_d;
    logic [3:0]       pos_q, pos_d;
    logic             ovf_q, ovf_d;

    logic [BW-1:0]    bcd_adj;
    logic [3:0]       cur_nib;
    logic             upper_zero;

    // Add-3 correction per nibble; 4-bit wrap, no carry between nibbles.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end else begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        shift_d = shift_q;
        iter_d  = iter_q;
        pos_d   = pos_q;
        ovf_d   = ovf_q;
        if (abort) begin
            state_d = S_IDLE;
            pos_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_CONV;
                        shift_d = value;
                        bcd_d   = '0;
                        iter_d  = '0;
                        pos_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                S_CONV: begin
                    bcd_d   = {bcd_adj[BW-2:0], shift_q[WIDTH-1]};
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    ovf_d   = ovf_q | bcd_adj[BW-1];
                    iter_d  = iter_q + 1'b1;
                    if (iter_q == CW'(WIDTH - 1)) begin
                        state_d = S_EMIT;
                        pos_d   = '0;
                    end
                end
                S_EMIT: begin
                    if (pos_q == 4'(DIGITS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        pos_d = pos_q + 4'd1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    pos_d   = '0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            bcd_q   <= '0;
            shift_q <= '0;
            iter_q  <= '0;
            pos_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            shift_q <= shift_d;
            iter_q  <= iter_d;
            pos_q   <= pos_d;
            ovf_q   <= ovf_d;
        end
    end

    // Digit select and leading-zero detect depend only on flops, never on inputs.
    always_comb begin
        cur_nib    = '0;
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (pos_q == 4'(i)) begin
                cur_nib = bcd_q[i*4 +: 4];
            end
            if ((4'(i) >= pos_q) && (bcd_q[i*4 +: 4] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        valid    = (state_q == S_EMIT);
        done     = (state_q == S_DONE);
        pos      = pos_q;
        overflow = ovf_q;
        data     = 4'd0;
        blank    = 1'b0;
        if (state_q == S_EMIT) begin
            data  = ovf_q ? 4'hE : cur_nib;
            blank = (pos_q != 4'd0) && !ovf_q && upper_zero;
        end
    end

endmodule

// File: tb/tb_calc_disp_seq.sv
// tb/tb_calc_disp_seq.sv - directed table-driven bench for calc_disp_seq
module tb_calc_disp_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [26:0] value;
    logic        busy;
    logic        valid;
    logic [3:0]  data;
    logic [3:0]  pos;
    logic        blank;
    logic        overflow;
    logic        done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    calc_disp_seq #(.WIDTH(27), .DIGITS(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .value    (value),
        .busy     (busy),
        .valid    (valid),
        .data     (data),
        .pos      (pos),
        .blank    (blank),
        .overflow (overflow),
        .done     (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [26:0] val;
        logic [31:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_valid"},    32'(valid),    32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_blank"},    32'(blank),    32'd0);
        check({tag, "_pos"},      32'(pos),      32'd0);
        check({tag, "_data"},     32'(data),     32'd0);
    endtask

    // Called at a negedge while IDLE; returns at the negedge of the idle cycle after done.
    // repulse: re-assert start with another value during CONV and EMIT.
    task automatic run_conv(input logic [26:0] v, input logic [31:0] exp_bcd,
                            input logic exp_ovf, input bit repulse);
        bit          conv_ok;
        logic [3:0]  exp_d;
        logic        exp_b;
        value = v;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        value = 27'h5A5A5A5;
        conv_ok = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            if (busy !== 1'b1 || valid !== 1'b0 || done !== 1'b0) conv_ok = 1'b0;
            if (repulse) start = (c == 10);
            @(negedge clock);
        end
        start = 1'b0;
        check("conv_phase", 32'(conv_ok), 32'd1);
        for (int i = 0; i < 8; i++) begin
            exp_d = exp_ovf ? 4'hE : 4'((exp_bcd >> (4 * i)) & 32'hF);
            exp_b = (i > 0) && !exp_ovf && ((exp_bcd >> (4 * i)) == 32'd0);
            check($sformatf("emit_valid_%0d", i), 32'(valid),    32'd1);
            check($sformatf("emit_pos_%0d", i),   32'(pos),      32'(i));
            check($sformatf("emit_data_%0d", i),  32'(data),     32'(exp_d));
            check($sformatf("emit_blank_%0d", i), 32'(blank),    32'(exp_b));
            check($sformatf("emit_ovf_%0d", i),   32'(overflow), 32'(exp_ovf));
            check($sformatf("emit_done_%0d", i),  32'(done),     32'd0);
            if (repulse) start = (i == 2);
            @(negedge clock);
        end
        start = 1'b0;
        check("done_pulse", 32'(done),  32'd1);
        check("done_busy",  32'(busy),  32'd1);
        check("done_valid", 32'(valid), 32'd0);
        @(negedge clock);
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_pos",  32'(pos),  32'd0);
    endtask

    initial begin
        vecs[0] = '{27'd12345,     32'h00012345, 1'b0};
        vecs[1] = '{27'd0,         32'h00000000, 1'b0};
        vecs[2] = '{27'd99999999,  32'h99999999, 1'b0};
        vecs[3] = '{27'd100000000, 32'h00000000, 1'b1};
        vecs[4] = '{27'h7FFFFFF,   32'h00000000, 1'b1};
        vecs[5] = '{27'd7,         32'h00000007, 1'b0};
        vecs[6] = '{27'd40,        32'h00000040, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        value = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_outputs_zero("reset");
        @(negedge clock);
        check_outputs_zero("idle");

        // Back-to-back runs: each start lands in the first idle cycle after done.
        for (int n = 0; n < 7; n++) begin
            run_conv(vecs[n].val, vecs[n].bcd, vecs[n].ovf, 1'b0);
        end

        // Start re-pulsed during CONV and EMIT must be ignored.
        run_conv(27'd12345, 32'h00012345, 1'b0, 1'b1);

        // Abort mid-EMIT at pos 3, on an overflowing value so overflow clearing is visible.
        value = 27'd100000000;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (27 + 3) @(negedge clock);
        check("abort_pre_pos", 32'(pos),      32'd3);
        check("abort_pre_ovf", 32'(overflow), 32'd1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check_outputs_zero("abort");
        @(negedge clock);
        check("abort_no_done", 32'(done), 32'd0);

        // Abort and start on the same edge: abort wins.
        abort = 1'b1;
        start = 1'b1;
        value = 27'd5;
        @(negedge clock);
        abort = 1'b0;
        start = 1'b0;
        check("abort_start_busy", 32'(busy), 32'd0);

        // Reset mid-CONV.
        value = 27'd12345;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        check("midconv_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check_outputs_zero("reset_midconv");

        // Reset with start on the same edge stays IDLE.
        start = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        check("reset_start_busy", 32'(busy), 32'd0);
        @(negedge clock);
        check("reset_start_busy2", 32'(busy), 32'd0);

        // A clean run afterwards still works.
        run_conv(27'd40, 32'h00000040, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
